// File: rtl/jam_pkg.sv
// Shared types and constants for the RSSI jamming-detection path.
// The control limits live here so the decision block and software models agree.
package jam_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitEwma,
    StDecide,
    StCheck
  } state_e;

  localparam int unsigned WarmupSamplesDef = 8;
  localparam int unsigned ConfirmCntDef    = 3;
  localparam int unsigned TimeoutCyclesDef = 64;

  // RSSI control limits in dBm; values outside [RssiLcl, RssiUcl] are suspicious.
  localparam int RssiUcl = -65;
  localparam int RssiLcl = -106;

  function automatic logic rssi_in_limits(input int v);
    return (v <= RssiUcl) && (v >= RssiLcl);
  endfunction

endpackage

// File: rtl/jam_debounce.sv
// Debounces decision-block alerts into a sticky jamming interrupt and
// keeps a saturating count of declared jamming events.
module jam_debounce
  import jam_pkg::*;
#(
  parameter int unsigned CONFIRM_CNT = ConfirmCntDef,
  parameter int unsigned EVT_W       = 16
) (
  input  logic             clk_h,
  input  logic             rst_h,
  input  logic             check,
  input  logic             alert,
  input  logic             irq_clear,
  input  logic             clr_cons,
  output logic             jam_irq,
  output logic [EVT_W-1:0] jam_events
);

  localparam int unsigned ConsW = $clog2(CONFIRM_CNT + 1);
  localparam logic [ConsW-1:0] ConsMax = ConsW'(CONFIRM_CNT);

  logic [ConsW-1:0] cons_q, cons_d;
  logic             irq_q, irq_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             evt;

  always_comb begin
    cons_d = cons_q;
    evt    = 1'b0;
    if (clr_cons) begin
      cons_d = '0;
    end else if (check) begin
      if (alert) begin
        // Once saturated, further alerts hold the count and never re-declare.
        if (cons_q != ConsMax) begin
          cons_d = cons_q + ConsW'(1);
          evt    = (cons_q == ConsMax - ConsW'(1));
        end
      end else begin
        cons_d = '0;
      end
    end
  end

  always_comb begin
    irq_d     = irq_q;
    evt_cnt_d = evt_cnt_q;
    if (evt) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end
    if (evt && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk_h) begin
    if (!rst_h) begin
      cons_q    <= '0;
      irq_q     <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      cons_q    <= cons_d;
      irq_q     <= irq_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign jam_irq    = irq_q;
  assign jam_events = evt_cnt_q;

endmodule

// File: rtl/ewma_jam_sequencer.sv
// Sequences RSSI samples through the EWMA engine and decision block, with
// warm-up gating, an engine timeout and debounced jamming interrupts.
module ewma_jam_sequencer
  import jam_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned WARMUP_SAMPLES = WarmupSamplesDef,
  parameter int unsigned CONFIRM_CNT    = ConfirmCntDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef,
  parameter int unsigned EVT_W          = 16
) (
  input  logic              clk_h,
  input  logic              rst_h,
  input  logic              cfg_enable,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_data,
  output logic              ewma_start,
  output logic [DATA_W-1:0] ewma_sample,
  input  logic              ewma_done,
  output logic              dec_enable,
  input  logic              dec_alert,
  output logic              jam_irq,
  output logic              err_timeout,
  input  logic              irq_clear,
  output logic [EVT_W-1:0]  jam_events,
  output logic              warm
);

  localparam int unsigned WarmW = $clog2(WARMUP_SAMPLES + 1);
  localparam int unsigned TmoW  = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WarmW-1:0] WarmMax = WarmW'(WARMUP_SAMPLES);
  localparam logic [TmoW-1:0]  TmoMax  = TmoW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [WarmW-1:0]  warm_q, warm_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              err_q, err_d;

  logic accept, tmo_hit, check, idle_off, clr_cons;

  assign accept   = sample_valid && sample_ready;
  assign tmo_hit  = (state_q == StWaitEwma) && !ewma_done && (tmo_q == TmoMax);
  assign idle_off = (state_q == StIdle) && !cfg_enable;
  assign clr_cons = tmo_hit || idle_off;
  assign warm     = (warm_q == WarmMax);

  // State register
  always_ff @(posedge clk_h) begin
    if (!rst_h) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StStart;
      end
      StStart: state_d = StWaitEwma;
      StWaitEwma: begin
        // Done takes priority over a simultaneous timeout terminal count.
        if (ewma_done) begin
          state_d = warm ? StDecide : StIdle;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StDecide: state_d = StCheck;
      StCheck:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    sample_ready = 1'b0;
    ewma_start   = 1'b0;
    dec_enable   = 1'b0;
    check        = 1'b0;
    unique case (state_q)
      StIdle:   sample_ready = cfg_enable;
      StStart:  ewma_start   = 1'b1;
      StDecide: dec_enable   = 1'b1;
      StCheck:  check        = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sample_d = sample_q;
    warm_d   = warm_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    if (accept) begin
      sample_d = sample_data;
    end
    if (idle_off) begin
      warm_d = '0;
    end else if ((state_q == StWaitEwma) && ewma_done && !warm) begin
      warm_d = warm_q + WarmW'(1);
    end
    if (state_q == StStart) begin
      tmo_d = '0;
    end else if ((state_q == StWaitEwma) && !ewma_done && !tmo_hit) begin
      tmo_d = tmo_q + TmoW'(1);
    end
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if (irq_clear) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_h) begin
    if (!rst_h) begin
      sample_q <= '0;
      warm_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      warm_q   <= warm_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign ewma_sample = sample_q;
  assign err_timeout = err_q;

  jam_debounce #(
    .CONFIRM_CNT (CONFIRM_CNT),
    .EVT_W       (EVT_W)
  ) u_debounce (
    .clk_h      (clk_h),
    .rst_h      (rst_h),
    .check      (check),
    .alert      (dec_alert),
    .irq_clear  (irq_clear),
    .clr_cons   (clr_cons),
    .jam_irq    (jam_irq),
    .jam_events (jam_events)
  );

endmodule

// File: doc/ewma_jam_sequencer.md
Name: ewma_jam_sequencer

Overview:
- Controller that sequences the RSSI jamming-detection path: accepts RSSI samples over a valid/ready handshake, launches the EWMA engine, then pulses the enable of the EWMA decision block.
- Samples the decision block's alert output and debounces it over consecutive samples into a sticky jamming interrupt.
- Enforces a warm-up window, guards the EWMA engine with a timeout, and keeps a saturating jamming-event counter for software.

Parameters:
- DATA_W, 32, width of RSSI sample and EWMA value (two's complement).
- WARMUP_SAMPLES, 8, number of completed EWMA updates before decisions are enabled.
- CONFIRM_CNT, 3, consecutive alerting decisions needed to declare jamming.
- TIMEOUT_CYCLES, 64, maximum wait in WAIT_EWMA for ewma_done.
- EVT_W, 16, width of the jamming-event counter.

Ports:
- clk_h  in  1  clock.
- rst_h  in  1  synchronous active-low reset.
- cfg_enable  in  1  enables sample acceptance.
- sample_valid  in  1  RSSI sample available.
- sample_ready  out  1  controller can accept a sample.
- sample_data  in  DATA_W  RSSI sample.
- ewma_start  out  1  one-cycle start pulse to the EWMA engine.
- ewma_sample  out  DATA_W  latched sample presented to the EWMA engine.
- ewma_done  in  1  EWMA engine finished; result valid.
- dec_enable  out  1  one-cycle pulse to the decision block's EnableDecision.
- dec_alert  in  1  decision block's registered alert output.
- jam_irq  out  1  sticky jamming interrupt.
- err_timeout  out  1  sticky EWMA-timeout flag.
- irq_clear  in  1  clears jam_irq and err_timeout.
- jam_events  out  EVT_W  saturating count of declared jamming events.
- warm  out  1  warm-up complete.

Behaviour:
- Clock and reset: single clock clk_h. Reset is synchronous and active-low on rst_h. Reset applies at any state, including mid-transaction, and abandons any in-flight sample.
- Reset values:
  - All outputs are 0; ewma_sample is 0.
  - FSM is in IDLE.
  - Warm-up, consecutive, timeout and event counters are 0.
- FSM states: IDLE, START, WAIT_EWMA, DECIDE, CHECK.
- IDLE:
  - sample_ready = cfg_enable (combinational from state and cfg_enable).
  - On sample_valid && sample_ready: latch sample_data into ewma_sample and go to START.
- START:
  - ewma_start = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT_EWMA.
- WAIT_EWMA:
  - If ewma_done and warm-up is incomplete: increment the warm-up counter (saturating at WARMUP_SAMPLES) and go to IDLE. No decision is made.
  - If ewma_done and warm-up is complete: go to DECIDE.
  - Otherwise increment the timeout counter. If it reaches TIMEOUT_CYCLES-1 without ewma_done: set err_timeout, reset the consecutive counter, go to IDLE.
  - If ewma_done and the timeout terminal count occur in the same cycle, done wins.
- DECIDE:
  - dec_enable = 1 for exactly this cycle.
  - Go to CHECK. The decision block updates its alert on the edge that ends DECIDE.
- CHECK:
  - dec_alert = 1: consecutive counter increments, saturating at CONFIRM_CNT.
  - dec_alert = 0: consecutive counter resets to 0.
  - If the counter transitions to CONFIRM_CNT in this cycle: set jam_irq and increment jam_events, saturating at all-ones.
  - Further alerts while saturated do not re-count. A new event requires a non-alerting decision first.
  - Go to IDLE.
- warm = (warm-up counter == WARMUP_SAMPLES).
- Latency: sample accept to dec_enable is 3 cycles plus EWMA latency. Minimum sample-to-sample spacing is 5 cycles.
- cfg_enable deassertion:
  - Blocks only new acceptance; an in-flight transaction completes.
  - The warm-up counter and consecutive counter reset when cfg_enable is low in IDLE.
- irq_clear:
  - Clears jam_irq and err_timeout on the next edge.
  - If set and clear occur in the same cycle, set wins.
  - jam_events is never cleared except by reset.
- ewma_done outside WAIT_EWMA is ignored.

Decomposition:
- Shared package jam_pkg holds:
  - the state enum typedef (IDLE..CHECK);
  - default constants for WARMUP_SAMPLES, CONFIRM_CNT, TIMEOUT_CYCLES;
  - the RSSI control limits UCL = -65 and LCL = -106, so the decision block and software models share them.
- One natural sub-module: jam_debounce, containing the consecutive counter, event detection, jam_irq and jam_events. Its inputs are a check strobe, dec_alert, irq_clear and the reset condition.

Test Plan:
- Reset then feed 8 samples with the engine answering in 2 cycles -> no dec_enable for any of them, warm rises after the 8th ewma_done; the 9th sample produces one dec_enable pulse exactly 1 cycle after ewma_done.
- After warm-up, dec_alert = 1 on 3 consecutive decisions -> jam_irq rises in the 3rd CHECK cycle, jam_events = 1; 2 further alerts leave jam_events = 1.
- Alert pattern 1,1,0,1,1,1 -> a single event, with jam_irq set only on the 6th decision; irq_clear asserted in that same cycle leaves jam_irq = 1.
- Engine never asserts ewma_done -> err_timeout = 1 after 64 cycles in WAIT_EWMA, consecutive counter reset, sample_ready high again in IDLE.
- rst_h low for 1 cycle during WAIT_EWMA -> all outputs 0 and state IDLE at the next edge; a later ewma_done is ignored.
- sample_valid held high with cfg_enable low -> sample_ready = 0 and no ewma_start; cfg_enable deasserted mid-transaction -> the current dec_enable still occurs, then warm-up restarts from 0.
